// File: rtl/hxdp_core_dispatch.sv
// Round-robin frame dispatcher from one RX AXI-Stream port to NUM_CORES eBPF cores,
// with per-core busy tracking, drop/back-pressure policy and a small register block.
module hxdp_core_dispatch #(
    parameter int NUM_CORES       = 4,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = 64,
    parameter int AXIS_USER_WIDTH = 1,
    parameter int REG_ADDR_WIDTH  = 8,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_STRB_WIDTH  = 4,
    parameter int DROP_WHEN_BUSY  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]               s_axis_tkeep,
    input  logic                                     s_axis_tlast,
    input  logic [AXIS_USER_WIDTH-1:0]               s_axis_tuser,

    output logic [NUM_CORES-1:0]                     m_axis_core_tvalid,
    input  logic [NUM_CORES-1:0]                     m_axis_core_tready,
    output logic [NUM_CORES*AXIS_DATA_WIDTH-1:0]     m_axis_core_tdata,
    output logic [NUM_CORES*AXIS_KEEP_WIDTH-1:0]     m_axis_core_tkeep,
    output logic [NUM_CORES-1:0]                     m_axis_core_tlast,
    output logic [NUM_CORES*AXIS_USER_WIDTH-1:0]     m_axis_core_tuser,

    input  logic [NUM_CORES-1:0]                     core_done,

    input  logic [REG_ADDR_WIDTH-1:0]                reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0]                reg_wr_data,
    input  logic [REG_STRB_WIDTH-1:0]                reg_wr_strb,
    input  logic                                     reg_wr_en,
    output logic                                     reg_wr_wait,
    output logic                                     reg_wr_ack,
    input  logic [REG_ADDR_WIDTH-1:0]                reg_rd_addr,
    input  logic                                     reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0]                reg_rd_data,
    output logic                                     reg_rd_wait,
    output logic                                     reg_rd_ack
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ENABLE = REG_ADDR_WIDTH'('h00);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_BUSY   = REG_ADDR_WIDTH'('h04);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_FWD    = REG_ADDR_WIDTH'('h08);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_DROP   = REG_ADDR_WIDTH'('h0C);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CTRL   = REG_ADDR_WIDTH'('h10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          sel_q, sel_d;
    logic [NUM_CORES-1:0]      busy_q, busy_d;
    logic [NUM_CORES-1:0]      enable_q, enable_d;
    logic [31:0]               fwd_cnt_q, fwd_cnt_d;
    logic [31:0]               drop_cnt_q, drop_cnt_d;
    logic                      wr_ack_q, wr_ack_d;
    logic                      rd_ack_q, rd_ack_d;
    logic [REG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [NUM_CORES-1:0]      cand;
    logic                      gnt_vld;
    logic [PTR_W-1:0]          gnt_idx;
    logic                      fwd_inc, drop_inc, cnt_clr;
    logic [REG_DATA_WIDTH-1:0] byte_mask, en_wr;
    logic                      unused_wr;

    // Round-robin search: first candidate at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        cand    = ~busy_q & enable_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (32'(rr_ptr_q) + i) % 32'(NUM_CORES);
            if (!gnt_vld && cand[PTR_W'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        sel_d              = sel_q;
        rr_ptr_d           = rr_ptr_q;
        busy_d             = busy_q & ~core_done;
        s_axis_tready      = 1'b0;
        m_axis_core_tvalid = '0;
        fwd_inc            = 1'b0;
        drop_inc           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid && gnt_vld) begin
                    busy_d[gnt_idx] = 1'b1;
                    sel_d           = gnt_idx;
                    rr_ptr_d        = PTR_W'((32'(gnt_idx) + 32'd1) % 32'(NUM_CORES));
                    state_d         = ST_FWD;
                end else if (s_axis_tvalid && (DROP_WHEN_BUSY != 0)) begin
                    state_d = ST_DROP;
                end
            end
            ST_FWD: begin
                m_axis_core_tvalid[sel_q] = s_axis_tvalid;
                s_axis_tready             = m_axis_core_tready[sel_q];
                if (s_axis_tvalid && m_axis_core_tready[sel_q] && s_axis_tlast) begin
                    fwd_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data sideband is broadcast to every slice; only tvalid is steered.
    assign m_axis_core_tdata = {NUM_CORES{s_axis_tdata}};
    assign m_axis_core_tkeep = {NUM_CORES{s_axis_tkeep}};
    assign m_axis_core_tuser = {NUM_CORES{s_axis_tuser}};
    assign m_axis_core_tlast = {NUM_CORES{s_axis_tlast}};

    always_comb begin
        for (int unsigned b = 0; b < REG_STRB_WIDTH; b++) begin
            byte_mask[b*8 +: 8] = {8{reg_wr_strb[b]}};
        end
        en_wr      = (REG_DATA_WIDTH'(enable_q) & ~byte_mask) | (reg_wr_data & byte_mask);
        enable_d   = enable_q;
        if (reg_wr_en && (reg_wr_addr == ADDR_ENABLE)) begin
            enable_d = en_wr[NUM_CORES-1:0];
        end
        cnt_clr    = reg_wr_en && (reg_wr_addr == ADDR_CTRL) && reg_wr_strb[0] && reg_wr_data[0];
        fwd_cnt_d  = cnt_clr ? '0 : fwd_cnt_q + 32'(fwd_inc);
        drop_cnt_d = cnt_clr ? '0 : drop_cnt_q + 32'(drop_inc);
        wr_ack_d   = reg_wr_en;
        rd_ack_d   = reg_rd_en;
        rd_data_d  = '0;
        if (reg_rd_en) begin
            case (reg_rd_addr)
                ADDR_ENABLE: rd_data_d = REG_DATA_WIDTH'(enable_q);
                ADDR_BUSY:   rd_data_d = REG_DATA_WIDTH'(busy_q);
                ADDR_FWD:    rd_data_d = REG_DATA_WIDTH'(fwd_cnt_q);
                ADDR_DROP:   rd_data_d = REG_DATA_WIDTH'(drop_cnt_q);
                default:     rd_data_d = '0;
            endcase
        end
    end

    assign unused_wr = ^{reg_wr_data, en_wr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            busy_q     <= '0;
            enable_q   <= '1;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            enable_q   <= enable_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign reg_wr_ack  = wr_ack_q;
    assign reg_rd_ack  = rd_ack_q;
    assign reg_rd_data = rd_data_q;
    assign reg_wr_wait = 1'b0;
    assign reg_rd_wait = 1'b0;

endmodule

// File: tb/tb_hxdp_core_dispatch.sv
// Bench for hxdp_core_dispatch: register table, directed dispatch corners, randomized
// frames against a frame-level model, and a back-pressure instance.
module tb_hxdp_core_dispatch;

    localparam int NC = 4;
    localparam int DW = 512;
    localparam int KW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic            s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [DW-1:0]   s_tdata = '0;
    logic [KW-1:0]   s_tkeep = '0;
    logic [0:0]      s_tuser = '0;
    logic [NC-1:0]   m_tvalid, m_tlast, m_tready = '1, core_done = '0;
    logic [NC*DW-1:0] m_tdata;
    logic [NC*KW-1:0] m_tkeep;
    logic [NC-1:0]   m_tuser;
    logic [7:0]      wr_addr = '0, rd_addr = '0;
    logic [31:0]     wr_data = '0, rd_data;
    logic [3:0]      wr_strb = '0;
    logic            wr_en = 1'b0, rd_en = 1'b0, wr_wait, wr_ack, rd_wait, rd_ack;

    hxdp_core_dispatch #(
        .NUM_CORES(NC), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(1),
        .REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(32), .REG_STRB_WIDTH(4), .DROP_WHEN_BUSY(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_core_tvalid(m_tvalid), .m_axis_core_tready(m_tready),
        .m_axis_core_tdata(m_tdata), .m_axis_core_tkeep(m_tkeep),
        .m_axis_core_tlast(m_tlast), .m_axis_core_tuser(m_tuser),
        .core_done(core_done),
        .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb), .reg_wr_en(wr_en),
        .reg_wr_wait(wr_wait), .reg_wr_ack(wr_ack),
        .reg_rd_addr(rd_addr), .reg_rd_en(rd_en), .reg_rd_data(rd_data),
        .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack)
    );

    // Second instance with back-pressure instead of dropping.
    logic            b_tvalid = 1'b0, b_tready, b_tlast = 1'b0;
    logic [NC-1:0]   b_mvalid, b_mlast, b_done = '0;
    logic [NC*DW-1:0] b_mdata;
    logic [NC*KW-1:0] b_mkeep;
    logic [NC-1:0]   b_muser;
    logic [31:0]     b_rd_data;
    logic            b_wr_wait, b_wr_ack, b_rd_wait, b_rd_ack;

    hxdp_core_dispatch #(
        .NUM_CORES(NC), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(1),
        .REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(32), .REG_STRB_WIDTH(4), .DROP_WHEN_BUSY(0)
    ) u_dut_bp (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tdata({DW{1'b0}}),
        .s_axis_tkeep({KW{1'b1}}), .s_axis_tlast(b_tlast), .s_axis_tuser(1'b0),
        .m_axis_core_tvalid(b_mvalid), .m_axis_core_tready({NC{1'b1}}),
        .m_axis_core_tdata(b_mdata), .m_axis_core_tkeep(b_mkeep),
        .m_axis_core_tlast(b_mlast), .m_axis_core_tuser(b_muser),
        .core_done(b_done),
        .reg_wr_addr(8'h00), .reg_wr_data(32'h0), .reg_wr_strb(4'h0), .reg_wr_en(1'b0),
        .reg_wr_wait(b_wr_wait), .reg_wr_ack(b_wr_ack),
        .reg_rd_addr(8'h00), .reg_rd_en(1'b0), .reg_rd_data(b_rd_data),
        .reg_rd_wait(b_rd_wait), .reg_rd_ack(b_rd_ack)
    );

    int checks = 0;
    int errors = 0;
    int onehot_err = 0;
    logic rand_ready = 1'b0;

    typedef struct {
        int          core;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic        user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];

    // Frame-level reference state.
    int        mdl_ptr = 0;
    logic [NC-1:0] mdl_busy = '0;
    logic [NC-1:0] mdl_en = '1;
    logic [31:0] mdl_fwd = 0, mdl_drop = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            for (int c = 0; c < NC; c++) begin
                if (m_tvalid[c] && m_tready[c])
                    obs_q.push_back('{c, m_tdata[c*DW +: DW], m_tkeep[c*KW +: KW], m_tuser[c], m_tlast[c]});
            end
            if ($countones(m_tvalid) > 1) onehot_err++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = rand_ready ? 4'($urandom) : '1;
    end

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("wr_ack", 512'(wr_ack), 512'(1));
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        rd_addr = a; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("rd_ack", 512'(rd_ack), 512'(1));
        d = rd_data;
        @(posedge clk); #1;
        check("rd_data_idle", 512'({rd_ack, rd_data}), 512'(0));
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(name, 512'(d), 512'(exp));
    endtask

    task automatic pulse_done(input logic [NC-1:0] mask);
        core_done = mask;
        @(posedge clk); #1;
        core_done = '0;
        mdl_busy &= ~mask;
    endtask

    function automatic int pick_core();
        for (int k = 0; k < NC; k++) begin
            int c = (mdl_ptr + k) % NC;
            if (mdl_en[c] && !mdl_busy[c]) return c;
        end
        return -1;
    endfunction

    // Sends one frame, predicts its fate, and compares observed beats with the prediction.
    task automatic send_frame(input int nbeats, output int got);
        int tgt;
        beat_t b;
        logic hs;
        int cnt;
        tgt = pick_core();
        if (tgt >= 0) begin
            mdl_busy[tgt] = 1'b1;
            mdl_ptr = (tgt + 1) % NC;
            mdl_fwd++;
        end else begin
            mdl_drop++;
        end
        for (int i = 0; i < nbeats; i++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.keep = {$urandom, $urandom};
            b.user = 1'($urandom);
            b.last = (i == nbeats - 1);
            b.core = tgt;
            if (tgt >= 0) exp_q.push_back(b);
            s_tdata = b.data; s_tkeep = b.keep; s_tuser = b.user; s_tlast = b.last;
            s_tvalid = 1'b1;
            hs = 1'b0; cnt = 0;
            while (!hs && cnt < 200) begin
                @(negedge clk);
                hs = s_tready;
                @(posedge clk); #1;
                cnt++;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL frame_timeout: beat %0d got no handshake in %0d cycles, required one", i, cnt);
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        got = (obs_q.size() > 0) ? obs_q[0].core : -1;
        check("beat_count", 512'(obs_q.size()), 512'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            beat_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("beat_core", 512'(o.core), 512'(e.core));
            check("beat_data", o.data, e.data);
            check("beat_side", 512'({o.keep, o.user, o.last}), 512'({e.keep, e.user, e.last}));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vec[12];

    task automatic b_frame(input logic [NC-1:0] exp_mask);
        logic hs;
        int cnt;
        logic [NC-1:0] vm;
        b_tvalid = 1'b1; b_tlast = 1'b1;
        hs = 1'b0; cnt = 0; vm = '0;
        while (!hs && cnt < 50) begin
            @(negedge clk);
            hs = b_tready;
            vm = b_mvalid;
            @(posedge clk); #1;
            cnt++;
        end
        b_tvalid = 1'b0; b_tlast = 1'b0;
        check("bp_handshake", 512'(hs), 512'(1));
        check("bp_target", 512'(vm), 512'(exp_mask));
    endtask

    initial begin
        int got;
        int rr_exp[6];
        logic stalled;
        int hs_n, cnt;

        vec[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h00, 32'hF};
        vec[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h04, 32'h0};
        vec[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h08, 32'h0};
        vec[3]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h0C, 32'h0};
        vec[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h10, 32'h0};
        vec[5]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h14, 32'h0};
        vec[6]  = '{1'b1, 8'h00, 32'hFFFFFFF5, 4'hF, 8'h00, 32'h5};
        vec[7]  = '{1'b1, 8'h00, 32'h0000000A, 4'h0, 8'h00, 32'h5};
        vec[8]  = '{1'b1, 8'h00, 32'h0000000A, 4'h1, 8'h00, 32'hA};
        vec[9]  = '{1'b1, 8'h40, 32'h12345678, 4'hF, 8'h40, 32'h0};
        vec[10] = '{1'b1, 8'h10, 32'h00000000, 4'hF, 8'h10, 32'h0};
        vec[11] = '{1'b1, 8'h00, 32'h0000000F, 4'h1, 8'h00, 32'hF};
        rr_exp = '{0, 2, 0, 2, 0, 2};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_s_tready", 512'(s_tready), 512'(0));
        check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
        check("rst_acks_data", 512'({wr_ack, rd_ack, rd_data}), 512'(0));
        check("rst_waits", 512'({wr_wait, rd_wait}), 512'(0));

        for (int i = 0; i < 12; i++) begin
            if (vec[i].wr) reg_write(vec[i].waddr, vec[i].wdata, vec[i].strb);
            read_check($sformatf("reg_vec%0d", i), vec[i].raddr, vec[i].exp);
        end

        // Four frames fill all cores in order, the fifth is dropped.
        for (int f = 0; f < 4; f++) begin
            send_frame(3, got);
            check("fill_order", 512'(got), 512'(f));
        end
        read_check("fill_fwd_cnt", 8'h08, 32'd4);
        read_check("fill_busy", 8'h04, 32'hF);
        send_frame(3, got);
        check("drop_no_core", 512'(got), 512'(-1));
        read_check("drop_cnt", 8'h0C, 32'd1);

        pulse_done('1);
        reg_write(8'h00, 32'h5, 4'hF);
        mdl_en = 4'h5;
        for (int f = 0; f < 6; f++) begin
            send_frame(2, got);
            check("rr_enable5", 512'(got), 512'(rr_exp[f]));
            if (got >= 0) pulse_done(NC'(1) << got);
        end
        reg_write(8'h00, 32'hF, 4'hF);
        mdl_en = '1;

        // Counter clear coinciding with the tlast handshake.
        fork
            send_frame(2, got);
            begin
                repeat (2) @(posedge clk);
                #1;
                reg_write(8'h10, 32'h1, 4'h1);
            end
        join
        mdl_fwd = 0; mdl_drop = 0;
        read_check("clr_race_fwd", 8'h08, mdl_fwd);
        read_check("clr_race_drop", 8'h0C, mdl_drop);
        pulse_done('1);

        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, 4), got);
            if ($urandom_range(0, 2) != 0) pulse_done(4'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                mdl_en = 4'($urandom);
                reg_write(8'h00, {28'h0, mdl_en}, 4'hF);
            end
        end
        rand_ready = 1'b0;
        read_check("rand_fwd_cnt", 8'h08, mdl_fwd);
        read_check("rand_drop_cnt", 8'h0C, mdl_drop);
        read_check("rand_busy", 8'h04, {28'h0, mdl_busy});
        read_check("rand_enable", 8'h00, {28'h0, mdl_en});

        // Reset on beat 2 of a 4-beat frame.
        pulse_done('1);
        reg_write(8'h00, 32'h7, 4'hF);
        s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = '1;
        hs_n = 0; cnt = 0;
        while (hs_n < 2 && cnt < 50) begin
            @(negedge clk);
            if (s_tready) hs_n++;
            @(posedge clk); #1;
            cnt++;
        end
        check("midrst_beats", 512'(hs_n), 512'(2));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_m_tvalid", 512'(m_tvalid), 512'(0));
        check("midrst_s_tready", 512'(s_tready), 512'(0));
        s_tvalid = 1'b0;
        obs_q.delete();
        mdl_busy = '0; mdl_en = '1; mdl_ptr = 0; mdl_fwd = 0; mdl_drop = 0;
        read_check("midrst_busy", 8'h04, 32'h0);
        read_check("midrst_enable", 8'h00, 32'hF);
        read_check("midrst_fwd", 8'h08, 32'h0);

        // Back-pressure instance: fill, stall, release core 2.
        for (int f = 0; f < 4; f++) b_frame(NC'(1) << f);
        b_tvalid = 1'b1; b_tlast = 1'b1;
        stalled = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (b_tready || (b_mvalid != '0)) stalled = 1'b0;
        end
        @(posedge clk); #1;
        check("bp_stalled", 512'(stalled), 512'(1));
        b_done = 4'b0100;
        @(posedge clk); #1;
        b_done = '0;
        b_frame(4'b0100);

        check("tvalid_onehot", 512'(onehot_err), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hxdp_core_dispatch.md
# hxdp_core_dispatch

Packet dispatcher between the RX AXI-Stream port and a parametrised array of hXDP eBPF cores. For each incoming frame it picks a free, enabled core by round-robin and forwards the whole frame to that core's AXI-Stream input. It marks the core busy until the core pulses `core_done`, and either back-pressures or drops frames when no core is free. Forwarded and dropped frame counts, busy status and the core enable mask are exposed on the register interface.

## Interface
- `NUM_CORES`, 4: number of eBPF cores, 1..32.
- `AXIS_DATA_WIDTH`, 512: tdata width.
- `AXIS_KEEP_WIDTH`, 64: tkeep width, AXIS_DATA_WIDTH/8.
- `AXIS_USER_WIDTH`, 1: tuser width, passed through unchanged.
- `REG_ADDR_WIDTH`, 8: register address width, byte addressed.
- `REG_DATA_WIDTH`, 32: register data width.
- `REG_STRB_WIDTH`, 4: REG_DATA_WIDTH/8.
- `DROP_WHEN_BUSY`, 1: 1 = discard a frame when no core is free; 0 = hold `s_axis_tready` low until a core frees.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `s_axis_tvalid`/`tready`/`tdata`/`tkeep`/`tlast`/`tuser`  in/out/in/in/in/in  1/1/DATA/KEEP/1/USER  RX frame stream.
- `m_axis_core_tvalid`  out  NUM_CORES  per-core valid.
- `m_axis_core_tready`  in  NUM_CORES  per-core ready.
- `m_axis_core_tdata`/`tkeep`/`tuser`  out  NUM_CORES×DATA/KEEP/USER  per-core buses, core i in slice i.
- `m_axis_core_tlast`  out  NUM_CORES  per-core last.
- `core_done`  in  NUM_CORES  one-cycle pulse: core i finished its frame.
- `reg_wr_addr`/`reg_wr_data`/`reg_wr_strb`/`reg_wr_en`  in  ADDR/DATA/STRB/1  register write.
- `reg_wr_wait`/`reg_wr_ack`  out  1/1.
- `reg_rd_addr`/`reg_rd_en`  in  ADDR/1  register read.
- `reg_rd_data`  out  DATA.
- `reg_rd_wait`/`reg_rd_ack`  out  1/1.

## Operation
- State machine with states IDLE, FWD and DROP.
- IDLE:
  - `s_axis_tready`=0.
  - If `s_axis_tvalid` and the candidate set (`~busy & enable`) is non-zero: grant `sel` = first set bit searching upward from `rr_ptr` with wrap. On the grant: set `busy[sel]`, `rr_ptr <= (sel+1) mod NUM_CORES`, go to FWD.
  - Else if `s_axis_tvalid` and DROP_WHEN_BUSY=1: go to DROP.
  - Else stay in IDLE.
- FWD:
  - `m_axis_core_tvalid[sel]`=`s_axis_tvalid`, `s_axis_tready`=`m_axis_core_tready[sel]`.
  - tdata/tkeep/tlast/tuser are driven combinationally to slice `sel`. All other slices have tvalid=0; their data is don't-care (driven as a broadcast copy).
  - On the handshake with tlast=1: fwd_cnt++, go to IDLE.
- DROP: `s_axis_tready`=1 and all m tvalid=0. On tvalid & tlast: drop_cnt++, go to IDLE.
- `core_done[i]` clears `busy[i]` in the same cycle it is sampled, and is ignored when `busy[i]`=0.
  - A grant cannot target a busy core, so grant and done never race on one core.
  - A done on `sel` while still in FWD clears busy, but forwarding continues to `sel` until tlast.
- Clearing a bit in `enable` never aborts a frame in flight; it only excludes that core from future grants.
- Register map, byte offsets:
  - 0x00 ENABLE: RW, bits[NUM_CORES-1:0], reset all ones; other bits read 0.
  - 0x04 BUSY: RO.
  - 0x08 FWD_CNT: RO, 32-bit, wraps.
  - 0x0C DROP_CNT: RO, 32-bit, wraps.
  - 0x10 CTRL: writing bit0=1 zeroes both counters; reads 0.
  - Unmapped reads return 0; unmapped writes are acked and ignored. Writes honour `reg_wr_strb` per byte.
- A counter clear in the same cycle as an increment: clear wins, result 0.

## Timing
- Grant costs one bubble cycle per frame: the first beat is accepted at the earliest one cycle after tvalid is seen in IDLE. The cut-through path has zero cycles of latency after that.
- Max throughput: N beats per N+1 cycles.
- `busy` set is visible on BUSY readback the cycle after the grant.
- `reg_rd_ack` and `reg_wr_ack` pulse exactly one cycle after `reg_rd_en`/`reg_wr_en`. `reg_rd_data` is valid with ack and 0 otherwise. `reg_rd_wait`=`reg_wr_wait`=0 always.
- Reset values:
  - State IDLE, `rr_ptr`=0, busy=0, enable=all ones, counters=0.
  - All tvalid=0, `s_axis_tready`=0, acks=0, `reg_rd_data`=0.
- Reset mid-frame abandons the frame. Leftover RX beats after reset are treated as the start of a new frame.

## Test plan
- NUM_CORES=4, all free, 4 frames of 3 beats, cores never done → cores 0,1,2,3 granted in order; FWD_CNT=4; BUSY=0xF.
- Fifth frame with all busy, DROP_WHEN_BUSY=1 → all 3 beats accepted, no m tvalid; DROP_CNT=1. With DROP_WHEN_BUSY=0: `s_axis_tready` stays 0 until `core_done[2]`, then the frame goes to core 2.
- ENABLE=0x5 and 6 back-to-back frames with immediate done pulses → grant order 0,2,0,2,0,2.
- `m_axis_core_tready[sel]` toggled randomly mid-frame → beats delivered in order without loss or duplication; tlast arrives on the same beat as the source.
- CTRL write 0x1 in the same cycle as a tlast handshake → FWD_CNT reads 0 afterward.
- Reset asserted on beat 2 of 4 → outputs return to reset values within 1 cycle; BUSY=0, ENABLE=0xF.
